// File: rtl/m20k_dp_arbiter.sv
// m20k_dp_arbiter: round-robin two-port arbiter for a shared dual-port M20K bank
module m20k_dp_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 16,
  parameter int PTRW = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ*DW-1:0] wmask,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]      A0,
  output logic [AW-1:0]      A1,
  output logic [DW-1:0]      D0,
  output logic [DW-1:0]      D1,
  output logic               CE0,
  output logic               CE1,
  output logic               WE0,
  output logic               WE1,
  output logic [DW-1:0]      WEM0,
  output logic [DW-1:0]      WEM1,
  input  logic [DW-1:0]      Q0,
  input  logic [DW-1:0]      Q1
);
  logic [PTRW-1:0] rr_ptr, i0, i1, last, nxt, t0_i, t1_i;
  logic            f0, f1, haz, g0, g1, t0_v, t1_v;
  always_comb begin
    int s;
    s  = 0;
    f0 = 1'b0;
    f1 = 1'b0;
    i0 = '0;
    i1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      if (req[s] && !f0) begin
        f0 = 1'b1;
        i0 = PTRW'(s);
      end else if (req[s] && !f1) begin
        f1 = 1'b1;
        i1 = PTRW'(s);
      end
    end
  end
  // a same-address pair involving a write idles port 1 rather than substituting the next requester
  assign haz  = f1 && (addr[i0*AW +: AW] == addr[i1*AW +: AW]) && (we[i0] || we[i1]);
  assign g0   = f0 && RSTN;
  assign g1   = f1 && !haz && RSTN;
  assign last = g1 ? i1 : i0;
  assign nxt  = (last == PTRW'(NREQ-1)) ? '0 : last + 1'b1;
  always_comb begin
    gnt = '0;
    if (g0) gnt[i0] = 1'b1;
    if (g1) gnt[i1] = 1'b1;
  end
  assign CE0  = g0;
  assign CE1  = g1;
  assign WE0  = g0 && we[i0];
  assign WE1  = g1 && we[i1];
  assign A0   = g0 ? addr[i0*AW +: AW]  : '0;
  assign A1   = g1 ? addr[i1*AW +: AW]  : '0;
  assign D0   = g0 ? wdata[i0*DW +: DW] : '0;
  assign D1   = g1 ? wdata[i1*DW +: DW] : '0;
  assign WEM0 = g0 ? wmask[i0*DW +: DW] : '0;
  assign WEM1 = g1 ? wmask[i1*DW +: DW] : '0;
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_ptr <= '0;
      t0_v   <= 1'b0;
      t1_v   <= 1'b0;
      t0_i   <= '0;
      t1_i   <= '0;
    end else begin
      if (g0) rr_ptr <= nxt;
      t0_v <= g0 && !we[i0];
      t1_v <= g1 && !we[i1];
      t0_i <= i0;
      t1_i <= i1;
    end
  end
  // tags are flops, so rvalid/rdata follow the macro's one-cycle read latency
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (t0_v) begin
      rvalid[t0_i]          = 1'b1;
      rdata[t0_i*DW +: DW]  = Q0;
    end
    if (t1_v) begin
      rvalid[t1_i]          = 1'b1;
      rdata[t1_i*DW +: DW]  = Q1;
    end
  end
endmodule

// File: tb/tb_m20k_dp_arbiter.sv
// tb_m20k_dp_arbiter: vector-table bench with a behavioural dual-port bank model
module tb_m20k_dp_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req, we, gnt, rvalid;
  logic [39:0] addr;
  logic [63:0] wdata, wmask, rdata;
  logic [9:0]  A0, A1;
  logic [15:0] D0, D1, WEM0, WEM1, Q0, Q1;
  logic        CE0, CE1, WE0, WE1;
  logic [15:0] mem [1024];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [39:0] a;
    logic [63:0] d;
    logic [63:0] m;
    logic [3:0]  eg;
    logic [1:0]  ece;
    logic [3:0]  erv;
    logic [63:0] erd;
  } vec_t;
  vec_t tv [18];

  m20k_dp_arbiter dut (
    .CLK(clk), .RSTN(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wmask(wmask), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .CE0(CE0), .CE1(CE1),
    .WE0(WE0), .WE1(WE1), .WEM0(WEM0), .WEM1(WEM1), .Q0(Q0), .Q1(Q1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (CE0) begin
      if (WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
      else Q0 <= mem[A0];
    end
    if (CE1) begin
      if (WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
      else Q1 <= mem[A1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0]  prv;
    logic [63:0] prd;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    Q0 = '0;
    Q1 = '0;
    tv[0]  = '{4'b0011, 4'b0011, {10'h0, 10'h0, 10'h020, 10'h010}, {16'h0, 16'h0, 16'h5678, 16'h1234}, {16'h0, 16'h0, 16'h00FF, 16'hFFFF}, 4'b0011, 2'b11, 4'b0000, 64'h0};
    tv[1]  = '{4'b1111, 4'b0000, {10'h040, 10'h030, 10'h020, 10'h010}, 64'h0, 64'h0, 4'b1100, 2'b11, 4'b1100, 64'h0};
    tv[2]  = '{4'b1111, 4'b0000, {10'h040, 10'h030, 10'h020, 10'h010}, 64'h0, 64'h0, 4'b0011, 2'b11, 4'b0011, {16'h0, 16'h0, 16'h0078, 16'h1234}};
    tv[3]  = '{4'b1111, 4'b0000, {10'h040, 10'h030, 10'h020, 10'h010}, 64'h0, 64'h0, 4'b1100, 2'b11, 4'b1100, 64'h0};
    tv[4]  = '{4'b0100, 4'b0100, {10'h0, 10'h155, 10'h0, 10'h0}, {16'h0, 16'hBEEF, 16'h0, 16'h0}, {16'h0, 16'hFFFF, 16'h0, 16'h0}, 4'b0100, 2'b01, 4'b0000, 64'h0};
    tv[5]  = '{4'b0100, 4'b0000, {10'h0, 10'h155, 10'h0, 10'h0}, 64'h0, 64'h0, 4'b0100, 2'b01, 4'b0100, {16'h0, 16'hBEEF, 16'h0, 16'h0}};
    tv[6]  = '{4'b0001, 4'b0001, {10'h0, 10'h0, 10'h0, 10'h155}, 64'h0, {16'h0, 16'h0, 16'h0, 16'h0F0F}, 4'b0001, 2'b01, 4'b0000, 64'h0};
    tv[7]  = '{4'b1000, 4'b0000, {10'h155, 10'h0, 10'h0, 10'h0}, 64'h0, 64'h0, 4'b1000, 2'b01, 4'b1000, {16'hB0E0, 16'h0, 16'h0, 16'h0}};
    tv[8]  = '{4'b0011, 4'b0001, {10'h0, 10'h0, 10'h3FF, 10'h3FF}, {16'h0, 16'h0, 16'h0, 16'hCAFE}, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 4'b0001, 2'b01, 4'b0000, 64'h0};
    tv[9]  = '{4'b0010, 4'b0000, {10'h0, 10'h0, 10'h3FF, 10'h0}, 64'h0, 64'h0, 4'b0010, 2'b01, 4'b0010, {16'h0, 16'h0, 16'hCAFE, 16'h0}};
    tv[10] = '{4'b1001, 4'b0000, {10'h010, 10'h0, 10'h0, 10'h010}, 64'h0, 64'h0, 4'b1001, 2'b11, 4'b1001, {16'h1234, 16'h0, 16'h0, 16'h1234}};
    tv[11] = '{4'b0011, 4'b0001, {10'h0, 10'h0, 10'h020, 10'h020}, {16'h0, 16'h0, 16'h0, 16'hAAAA}, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 4'b0010, 2'b01, 4'b0010, {16'h0, 16'h0, 16'h0078, 16'h0}};
    tv[12] = '{4'b0101, 4'b0001, {10'h0, 10'h030, 10'h0, 10'h020}, {16'h0, 16'h0, 16'h0, 16'hAAAA}, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 4'b0101, 2'b11, 4'b0100, 64'h0};
    tv[13] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 64'h0, 4'b0000, 2'b00, 4'b0000, 64'h0};
    tv[14] = '{4'b1111, 4'b0000, {10'h3FF, 10'h155, 10'h020, 10'h010}, 64'h0, 64'h0, 4'b0110, 2'b11, 4'b0110, {16'h0, 16'hB0E0, 16'hAAAA, 16'h0}};
    tv[15] = '{4'b1111, 4'b0000, {10'h3FF, 10'h155, 10'h020, 10'h010}, 64'h0, 64'h0, 4'b1001, 2'b11, 4'b1001, {16'hCAFE, 16'h0, 16'h0, 16'h1234}};
    tv[16] = '{4'b0111, 4'b0010, {10'h0, 10'h040, 10'h040, 10'h050}, {16'h0, 16'h0, 16'h1111, 16'h0}, {16'h0, 16'h0, 16'hFFFF, 16'h0}, 4'b0010, 2'b01, 4'b0000, 64'h0};
    tv[17] = '{4'b0101, 4'b0000, {10'h0, 10'h040, 10'h0, 10'h050}, 64'h0, 64'h0, 4'b0101, 2'b11, 4'b0101, {16'h0, 16'h1111, 16'h0, 16'h0}};

    rstn = 1'b0;
    req = 4'b1111;
    we = 4'b0000;
    addr = {10'h040, 10'h030, 10'h020, 10'h010};
    wdata = '0;
    wmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {60'h0, gnt}, 64'h0);
    chk("rst_ce", {62'h0, CE1, CE0}, 64'h0);
    chk("rst_rvalid", {60'h0, rvalid}, 64'h0);
    rstn = 1'b1;
    #1;
    chk("release_gnt", {60'h0, gnt}, 64'h3);
    chk("release_ce", {62'h0, CE1, CE0}, 64'h3);
    req = 4'b0000;

    prv = '0;
    prd = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("rvalid[%0d]", i), {60'h0, rvalid}, {60'h0, prv});
      chk($sformatf("rdata[%0d]", i), rdata, prd);
      req = tv[i].req;
      we = tv[i].we;
      addr = tv[i].a;
      wdata = tv[i].d;
      wmask = tv[i].m;
      #1;
      chk($sformatf("gnt[%0d]", i), {60'h0, gnt}, {60'h0, tv[i].eg});
      chk($sformatf("ce[%0d]", i), {62'h0, CE1, CE0}, {62'h0, tv[i].ece});
      prv = tv[i].erv;
      prd = tv[i].erd;
    end
    @(negedge clk);
    chk("rvalid_last", {60'h0, rvalid}, {60'h0, prv});
    chk("rdata_last", rdata, prd);

    req = 4'b0010;
    we = 4'b0000;
    addr = {10'h0, 10'h0, 10'h020, 10'h0};
    #1;
    chk("midrst_gnt_pre", {60'h0, gnt}, 64'h2);
    rstn = 1'b0;
    #1;
    chk("midrst_gnt", {60'h0, gnt}, 64'h0);
    chk("midrst_ce", {62'h0, CE1, CE0}, 64'h0);
    @(posedge clk);
    #1;
    chk("midrst_rvalid", {60'h0, rvalid}, 64'h0);
    @(negedge clk);
    req = 4'b0000;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rvalid0", {60'h0, rvalid}, 64'h0);
    @(posedge clk);
    #1;
    chk("post_rst_rvalid1", {60'h0, rvalid}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m20k_dp_arbiter.md
Name: m20k_dp_arbiter

Overview:
- Shares one dual-port 1024x16 M20K bank between NREQ requesters.
- Each cycle it grants up to two requests, one per physical port, using round-robin priority.
- Resolves same-address cross-port hazards and steers the one-cycle-latency read data back to the requester that issued the read.
- Sits between accelerator datapath clients and the memory macro, and drives the macro's A/D/CE/WE/WEM pins directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 10, address width (bank depth 2^AW words).
- DW, 16, data width and write-mask width.
- PTRW, 2, round-robin pointer width; must satisfy 2^PTRW >= NREQ.

Ports:
- CLK  in  1  clock; all state on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req  in  NREQ  request valid, one bit per requester.
- we  in  NREQ  1 = write, 0 = read.
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- wmask  in  NREQ*DW  packed per-bit write mask.
- gnt  out  NREQ  combinational grant, same cycle as the memory access.
- rvalid  out  NREQ  registered read-data valid.
- rdata  out  NREQ*DW  read data, valid when the matching rvalid bit is high.
- A0, A1  out  AW  memory addresses, port 0 and port 1.
- D0, D1  out  DW  memory write data.
- CE0, CE1  out  1  memory port enables.
- WE0, WE1  out  1  memory write enables.
- WEM0, WEM1  out  DW  memory write masks.
- Q0, Q1  in  DW  memory read data, valid 1 cycle after the access.

Behaviour:

Reset (RSTN low, asynchronous):
- rr_ptr = 0.
- rvalid = 0.
- Read-tag registers cleared.
- Reads outstanding when reset asserts are discarded; no rvalid is ever produced for them.
- Combinational outputs are gated while RSTN is low: gnt = 0, CE0 = CE1 = 0, WE0 = WE1 = 0.

Handshake:
- A requester holds req/we/addr/wdata/wmask stable until it sees gnt in the same cycle.
- gnt[i] high means the access is issued to the memory in that cycle.
- A requester may re-request in the very next cycle.

Selection (combinational):
- Scan requesters in order rr_ptr, rr_ptr+1, ... modulo NREQ.
- First pending request goes to port 0; second pending request goes to port 1.
- Port 0 signals: CE0 = 1, WE0 = we, A0 = addr, D0 = wdata, WEM0 = wmask. Port 1 likewise.
- Ungranted ports: CE = 0, WE = 0; A/D/WEM are don't-care but driven to 0.

Hazard rule:
- If both candidates have equal addresses and at least one is a write, the port-1 candidate is withheld.
- The withheld requester is not granted and port 1 stays idle this cycle; the next requester in the scan is not substituted.
- Read/read to the same address is permitted on both ports.

Pointer update:
- If any grant occurred, rr_ptr <= (index of the last granted requester + 1) mod NREQ.
- Otherwise rr_ptr holds.
- Consequence: any continuously requesting client is granted within ceil(NREQ/2)+1 cycles.

Read return:
- Each port has a registered tag {valid, requester index}, set when that port issues a read.
- The cycle after the access: rvalid[idx] = 1 and rdata[idx] = Q0 or Q1 for the issuing port. rdata is combinational from Q, selected by the registered tag.
- Read latency is exactly 1 cycle from gnt to rvalid.
- Writes produce no rvalid.
- A single requester cannot own both ports in one cycle, so the two tags never collide.
- rdata for requesters without rvalid is 0.

Read-during-write:
- A same-port read-after-write in consecutive cycles returns the new data.
- Same-cycle cross-port same-address access is prevented by the hazard rule.

Test Plan:
- Reset: hold RSTN=0 with req=4'b1111 -> gnt=0, CE0=CE1=0, rvalid=0. Release RSTN -> port 0 serves req0, port 1 serves req1.
- Round-robin: all four requesters issue reads continuously -> grant pairs cycle {0,1},{2,3},{0,1},... and each rvalid pulses exactly 1 cycle after its gnt.
- Write then read: req2 writes addr 0x155, data 0xBEEF, mask 0xFFFF; next cycle req2 reads 0x155 -> rvalid[2] one cycle later with rdata[2]=0xBEEF, returned on the port that issued the read.
- Hazard: rr_ptr=0, req0 writes 0x3FF, req1 reads 0x3FF -> only gnt[0], CE1=0. Next cycle req1 is granted on port 0 (rr_ptr=1) and returns the newly written value.
- Read/read same address: req0 and req3 both read 0x010 (holding 0x1234) -> both granted same cycle; rvalid[0] and rvalid[3] high next cycle, both returning 0x1234.
- Reset mid-read: grant a read to req1, assert RSTN=0 before the next edge -> rvalid stays 0 and no stale rvalid appears after release.
